// File: rtl/eth_rx_frame_filter_if.sv
// rtl/eth_rx_frame_filter_if.sv - 64-bit AXI-Stream style beat bundle for the RX frame filter
`timescale 1ns/1ps
interface eth_rx_frame_filter_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - store-and-forward RX frame buffer dropping bad and overflowing frames
`timescale 1ns/1ps
module eth_rx_frame_filter #(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  eth_rx_frame_filter_if.slave  s_axis_rx,
  eth_rx_frame_filter_if.master m_axis_rx,
  output logic [CNT_WIDTH-1:0]  stat_rx_good,
  output logic [CNT_WIDTH-1:0]  stat_drop_err,
  output logic [CNT_WIDTH-1:0]  stat_drop_ovf,
  output logic [ADDR_WIDTH-1:0] buf_frames
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int WORD_W = 73;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [WORD_W-1:0]     rd_word_q, o_word_q;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, wr_ptr_inc;
  logic [CNT_WIDTH-1:0]  good_q, err_q, ovf_q;
  logic [ADDR_WIDTH-1:0] frames_q;
  logic                  full, we, inc_good, inc_err, inc_ovf;
  logic                  has_data, rd_en, rd_vld_q, o_vld_q, move_out, out_fire, out_last_fire;

  // The MAC cannot be stalled, so the input side always reports ready.
  assign s_axis_rx.tready = 1'b1;

  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr_q);

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (s_axis_rx.tvalid) begin
      if (state_q == DROP) begin
        if (s_axis_rx.tlast) state_d = IDLE;
      end else if (s_axis_rx.tlast) begin
        state_d = IDLE;
      end else if (full) begin
        state_d = DROP;
      end else begin
        state_d = RECV;
      end
    end
  end

  always_comb begin
    we          = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    inc_good    = 1'b0;
    inc_err     = 1'b0;
    inc_ovf     = 1'b0;
    if (s_axis_rx.tvalid) begin
      if (state_q == DROP) begin
        inc_ovf = s_axis_rx.tlast;
      end else if (s_axis_rx.tlast && s_axis_rx.tuser) begin
        wr_ptr_d = wr_commit_q;
        inc_err  = 1'b1;
      end else if (full) begin
        // Rewind so the partial frame is discarded as a whole.
        wr_ptr_d = wr_commit_q;
        inc_ovf  = s_axis_rx.tlast;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_inc;
        if (s_axis_rx.tlast) begin
          wr_commit_d = wr_ptr_inc;
          inc_good    = 1'b1;
        end
      end
    end
  end

  // Read pipeline: RAM output register, then the downstream output register.
  assign has_data      = (rd_ptr_q != wr_commit_q);
  assign out_fire      = o_vld_q && m_axis_rx.tready;
  assign out_last_fire = out_fire && o_word_q[72];
  assign move_out      = rd_vld_q && (!o_vld_q || m_axis_rx.tready);
  assign rd_en         = has_data && (!rd_vld_q || move_out);

  always_ff @(posedge clk156) begin
    if (we) mem_q[wr_ptr_q] <= {s_axis_rx.tlast, s_axis_rx.tkeep, s_axis_rx.tdata};
    if (rd_en) rd_word_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rd_ptr_q <= '0;
      rd_vld_q <= 1'b0;
      o_vld_q  <= 1'b0;
      o_word_q <= '0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      rd_vld_q <= rd_en | (rd_vld_q & ~move_out);
      if (move_out) o_word_q <= rd_word_q;
      o_vld_q  <= move_out | (o_vld_q & ~out_fire);
    end
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      good_q   <= '0;
      err_q    <= '0;
      ovf_q    <= '0;
      frames_q <= '0;
    end else begin
      if (inc_good) good_q <= good_q + CNT_ONE;
      if (inc_err)  err_q  <= err_q + CNT_ONE;
      if (inc_ovf)  ovf_q  <= ovf_q + CNT_ONE;
      if (inc_good && !out_last_fire) frames_q <= frames_q + PTR_ONE;
      else if (!inc_good && out_last_fire) frames_q <= frames_q - PTR_ONE;
    end
  end

  assign m_axis_rx.tvalid = o_vld_q;
  assign m_axis_rx.tlast  = o_word_q[72];
  assign m_axis_rx.tkeep  = o_word_q[71:64];
  assign m_axis_rx.tdata  = o_word_q[63:0];
  assign m_axis_rx.tuser  = 1'b0;
  assign stat_rx_good     = good_q;
  assign stat_drop_err    = err_q;
  assign stat_drop_ovf    = ovf_q;
  assign buf_frames       = frames_q;

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb/tb_eth_rx_frame_filter.sv - self-checking bench for eth_rx_frame_filter
`timescale 1ns/1ps
module tb_eth_rx_frame_filter;
  localparam int AW  = 4;
  localparam int CW  = 32;
  localparam int CAP = (1 << AW) - 1;

  typedef logic [73:0] beat_t;  // {tuser, tlast, tkeep, tdata}

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] stat_good, stat_err, stat_ovf;
  logic [AW-1:0] buf_frames;

  eth_rx_frame_filter_if s_if ();
  eth_rx_frame_filter_if m_if ();

  eth_rx_frame_filter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk156        (clk),
    .eth_rst_n     (rst_n),
    .s_axis_rx     (s_if),
    .m_axis_rx     (m_if),
    .stat_rx_good  (stat_good),
    .stat_drop_err (stat_err),
    .stat_drop_ovf (stat_ovf),
    .buf_frames    (buf_frames)
  );

  always #3 clk = ~clk;

  int    checks = 0, failures = 0;
  beat_t exp_q[$], got_q[$];
  int    exp_good = 0, exp_err = 0, exp_ovf = 0;
  int    cyc = 0, first_xfer = 0, last_xfer = 0, hold_viol = 0;
  int    rmode = 0;  // 0: tready driven by tasks, 1: random, 2: toggling
  beat_t held;
  logic  stalled = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && (!m_if.tvalid || {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata} !== held))
        hold_viol++;
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back({m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata});
        if (got_q.size() == 1) first_xfer = cyc;
        last_xfer = cyc;
      end
      stalled = m_if.tvalid && !m_if.tready;
      held    = {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 1) m_if.tready = 1'($urandom_range(0, 1));
    else if (rmode == 2) m_if.tready = ~m_if.tready;
  end

  function automatic int qdiff();
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = u;
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
  endtask

  // fate: 0 = expected forwarded, 1 = MAC-flagged bad, 2 = expected overflow drop
  task automatic send_frame(input int len, input int fate, input logic [7:0] lkeep);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      l = (i == len - 1);
      k = l ? lkeep : 8'hFF;
      send_beat(d, k, l, l && (fate == 1));
      if (fate == 0) exp_q.push_back({1'b0, l, k, d});
    end
    if (fate == 0) exp_good++;
    else if (fate == 1) exp_err++;
    else exp_ovf++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((got_q.size() < exp_q.size() || m_if.tvalid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL drain_timeout got=%0d beats required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tuser = 0;
    m_if.tready = 0;
    #1 rst_n = 1'b0;
    #20;
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b req=0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 64'd0 || m_if.tkeep !== 8'd0 || m_if.tlast !== 1'b0)
      begin failures++; $display("FAIL rst_data got=%h/%h/%b req=0", m_if.tdata, m_if.tkeep, m_if.tlast); end
    checks++; if (stat_good !== 0 || stat_err !== 0 || stat_ovf !== 0)
      begin failures++; $display("FAIL rst_stats got=%0d/%0d/%0d req=0", stat_good, stat_err, stat_ovf); end
    checks++; if (buf_frames !== 0) begin failures++; $display("FAIL rst_buf_frames got=%0d req=0", buf_frames); end
    checks++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b req=1", s_if.tready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic v0, v1, v2;
    got_q.delete(); exp_q.delete();
    m_if.tready = 1'b1;
    send_frame(8, 0, 8'h0F);
    v0 = m_if.tvalid;
    @(posedge clk); #1; v1 = m_if.tvalid;
    @(posedge clk); #1; v2 = m_if.tvalid;
    checks++; if ({v0, v1, v2} !== 3'b001)
      begin failures++; $display("FAIL t1_latency got=%b req=001", {v0, v1, v2}); end
    wait_drain();
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL t1_beats diffs=%0d req=0", qdiff()); end
    checks++; if (stat_good !== CW'(exp_good)) begin failures++; $display("FAIL t1_good got=%0d req=%0d", stat_good, exp_good); end
  endtask

  task automatic test_bad_frame_drop();
    got_q.delete(); exp_q.delete();
    m_if.tready = 1'b1;
    send_frame(4, 0, 8'hFF);
    send_frame(6, 1, 8'h03);
    send_frame(3, 0, 8'h01);
    wait_drain();
    checks++; if (qdiff() !== 0 || got_q.size() !== 7) begin failures++; $display("FAIL t2_beats diffs=%0d n=%0d req=0/7", qdiff(), got_q.size()); end
    checks++; if (stat_err !== CW'(exp_err)) begin failures++; $display("FAIL t2_err got=%0d req=%0d", stat_err, exp_err); end
    checks++; if (stat_good !== CW'(exp_good)) begin failures++; $display("FAIL t2_good got=%0d req=%0d", stat_good, exp_good); end
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    m_if.tready = 1'b0;
    send_frame(CAP + 1, 2, 8'hFF);
    idle(4);
    checks++; if (stat_ovf !== CW'(exp_ovf)) begin failures++; $display("FAIL t3_ovf_edge got=%0d req=%0d", stat_ovf, exp_ovf); end
    checks++; if (m_if.tvalid !== 1'b0 || buf_frames !== 0) begin failures++; $display("FAIL t3_nothing_out got=%b/%0d req=0/0", m_if.tvalid, buf_frames); end
    send_frame(CAP, 0, 8'h7F);
    idle(4);
    checks++; if (m_if.tvalid !== 1'b1 || buf_frames !== 1) begin failures++; $display("FAIL t3_cap_fit got=%b/%0d req=1/1", m_if.tvalid, buf_frames); end
    m_if.tready = 1'b1;
    wait_drain();
    m_if.tready = 1'b0;
    send_frame(20, 2, 8'hFF);
    idle(4);
    checks++; if (stat_ovf !== CW'(exp_ovf)) begin failures++; $display("FAIL t3_ovf20 got=%0d req=%0d", stat_ovf, exp_ovf); end
    checks++; if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL t3_tvalid got=%b req=0", m_if.tvalid); end
    send_frame(5, 0, 8'h3F);
    idle(4);
    checks++; if (got_q.size() !== CAP) begin failures++; $display("FAIL t3_held got=%0d req=%0d", got_q.size(), CAP); end
    m_if.tready = 1'b1;
    wait_drain();
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL t3_beats diffs=%0d req=0", qdiff()); end
    checks++; if (stat_good !== CW'(exp_good)) begin failures++; $display("FAIL t3_good got=%0d req=%0d", stat_good, exp_good); end
  endtask

  task automatic test_back_to_back();
    int prev, bf, seq_bad, n;
    got_q.delete(); exp_q.delete();
    hold_viol = 0;
    m_if.tready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(2, 0, 8'(f + 1));
    idle(3);
    checks++; if (buf_frames !== 3) begin failures++; $display("FAIL t4_buf3 got=%0d req=3", buf_frames); end
    prev = 3; seq_bad = 0; n = 0;
    rmode = 2;
    while (!(got_q.size() == 6 && prev == 0) && n < 200) begin
      @(posedge clk); #1;
      bf = int'(buf_frames);
      if (bf != prev) begin
        if (bf != prev - 1) seq_bad++;
        prev = bf;
      end
      n++;
    end
    rmode = 0;
    m_if.tready = 1'b1;
    checks++; if (seq_bad !== 0 || prev !== 0) begin failures++; $display("FAIL t4_buf_seq bad=%0d last=%0d req=0/0", seq_bad, prev); end
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL t4_beats diffs=%0d req=0", qdiff()); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL t4_hold got=%0d req=0", hold_viol); end
  endtask

  task automatic test_random_mix();
    int nf, len, fate;
    got_q.delete(); exp_q.delete();
    hold_viol = 0;
    rmode = 1;
    for (int b = 0; b < 30; b++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        len  = $urandom_range(1, 4);
        fate = ($urandom_range(0, 3) == 0) ? 1 : 0;
        send_frame(len, fate, 8'($urandom_range(1, 255)));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      wait_drain();
    end
    rmode = 0;
    m_if.tready = 1'b1;
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL rnd_beats diffs=%0d req=0", qdiff()); end
    checks++; if (stat_good !== CW'(exp_good) || stat_err !== CW'(exp_err) || stat_ovf !== CW'(exp_ovf))
      begin failures++; $display("FAIL rnd_stats got=%0d/%0d/%0d req=%0d/%0d/%0d", stat_good, stat_err, stat_ovf, exp_good, exp_err, exp_ovf); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL rnd_hold got=%0d req=0", hold_viol); end
    checks++; if (buf_frames !== 0) begin failures++; $display("FAIL rnd_buf got=%0d req=0", buf_frames); end
  endtask

  task automatic test_line_rate();
    got_q.delete(); exp_q.delete();
    m_if.tready = 1'b1;
    for (int i = 0; i < 1000; i++) send_frame(1, 0, 8'($urandom_range(1, 255)));
    wait_drain();
    checks++; if (qdiff() !== 0) begin failures++; $display("FAIL t6_beats diffs=%0d req=0", qdiff()); end
    checks++; if (last_xfer - first_xfer !== 999) begin failures++; $display("FAIL t6_rate span=%0d req=999", last_xfer - first_xfer); end
    checks++; if (stat_ovf !== CW'(exp_ovf) || stat_err !== CW'(exp_err))
      begin failures++; $display("FAIL t6_drops got=%0d/%0d req=%0d/%0d", stat_ovf, stat_err, exp_ovf, exp_err); end
    checks++; if (stat_good !== CW'(exp_good)) begin failures++; $display("FAIL t6_good got=%0d req=%0d", stat_good, exp_good); end
  endtask

  task automatic test_reset_mid_frame();
    got_q.delete(); exp_q.delete();
    m_if.tready = 1'b0;
    send_frame(3, 0, 8'hFF);
    idle(3);
    checks++; if (m_if.tvalid !== 1'b1) begin failures++; $display("FAIL t5_pre_tvalid got=%b req=1", m_if.tvalid); end
    for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== 64'd0) begin failures++; $display("FAIL t5_async_out got=%b/%h req=0/0", m_if.tvalid, m_if.tdata); end
    checks++; if (stat_good !== 0 || stat_err !== 0 || stat_ovf !== 0)
      begin failures++; $display("FAIL t5_async_stats got=%0d/%0d/%0d req=0", stat_good, stat_err, stat_ovf); end
    checks++; if (buf_frames !== 0) begin failures++; $display("FAIL t5_async_buf got=%0d req=0", buf_frames); end
    exp_good = 0; exp_err = 0; exp_ovf = 0;
    got_q.delete(); exp_q.delete();
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    send_frame(8, 0, 8'hF0);
    wait_drain();
    checks++; if (qdiff() !== 0 || got_q.size() !== 8) begin failures++; $display("FAIL t5_beats diffs=%0d n=%0d req=0/8", qdiff(), got_q.size()); end
    checks++; if (stat_good !== 1) begin failures++; $display("FAIL t5_good got=%0d req=1", stat_good); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_frame_drop();
    test_overflow();
    test_back_to_back();
    test_random_mix();
    test_line_rate();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
